// File: rtl/mult_div.sv
// mult_div: iterative-latency multiply/divide unit owning the HI/LO registers.
//
// Long operations (MULT, MULTU, DIV, DIVU and, when built with MDU_MADD_EN,
// MADD/MSUB) latch their operands on the start edge, hold busy for a fixed
// number of cycles, then write HI/LO on the edge that ends the last busy
// cycle. MTHI/MTLO write directly from IDLE without asserting busy.
//
// Build option: define MDU_MADD_EN to add MADD (op 6) and MSUB (op 7);
// otherwise those op codes are ignored and no accumulate path exists.
//
// Ports:
//   clk    in   clock, all state updates on rising edge
//   reset  in   synchronous active-high reset
//   start  in   qualifies op/A/B for one cycle
//   op     in   [2:0] 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6 MADD, 7 MSUB
//   A, B   in   [31:0] rs / rt operands
//   busy   out  high while a long operation is in flight
//   HI, LO out  [31:0] architectural HI/LO registers
module mult_div #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW = $clog2(MAX_CYCLES + 1);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    // Initialisers give power-up values equal to the reset values.
    state_t          state = IDLE;
    logic [CW-1:0]   cnt   = '0;
    logic [2:0]      op_r  = '0;
    logic [31:0]     a_r   = '0;
    logic [31:0]     b_r   = '0;
    logic [31:0]     hi_r  = '0;
    logic [31:0]     lo_r  = '0;

    state_t          state_next;
    logic [CW-1:0]   cnt_next;
    logic [2:0]      op_next;
    logic [31:0]     a_next, b_next, hi_next, lo_next;

    logic            op_long, op_is_div;
    logic [63:0]     sprod, uprod;
    logic [31:0]     a_mag, b_mag, q_mag, r_mag, q_s, r_s, q_u, r_u;

    assign busy = (state == BUSY);
    assign HI   = hi_r;
    assign LO   = lo_r;

`ifdef MDU_MADD_EN
    assign op_long = (op <= OP_DIVU) || (op >= 3'd6);
`else
    assign op_long = (op <= OP_DIVU);
`endif
    assign op_is_div = (op == OP_DIV) || (op == OP_DIVU);

    // Low 64 bits of the product of sign-extended operands is the signed product.
    assign sprod = {{32{a_r[31]}}, a_r} * {{32{b_r[31]}}, b_r};
    assign uprod = {32'd0, a_r} * {32'd0, b_r};

    // Signed divide on magnitudes; 0x80000000 / -1 falls out as 0x80000000 rem 0.
    assign a_mag = a_r[31] ? -a_r : a_r;
    assign b_mag = b_r[31] ? -b_r : b_r;
    assign q_mag = (b_r == '0) ? '0 : a_mag / b_mag;
    assign r_mag = (b_r == '0) ? '0 : a_mag % b_mag;
    assign q_s   = (a_r[31] ^ b_r[31]) ? -q_mag : q_mag;
    assign r_s   = a_r[31] ? -r_mag : r_mag;
    assign q_u   = (b_r == '0) ? '0 : a_r / b_r;
    assign r_u   = (b_r == '0) ? '0 : a_r % b_r;

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        op_next    = op_r;
        a_next     = a_r;
        b_next     = b_r;
        hi_next    = hi_r;
        lo_next    = lo_r;
        case (state)
            IDLE: begin
                if (start) begin
                    if (op_long) begin
                        op_next    = op;
                        a_next     = A;
                        b_next     = B;
                        cnt_next   = op_is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                        state_next = BUSY;
                    end else if (op == OP_MTHI) begin
                        hi_next = A;
                    end else if (op == OP_MTLO) begin
                        lo_next = A;
                    end
                end
            end
            BUSY: begin
                // Completion on the edge ending the last busy cycle (cnt == 1).
                if (cnt <= CW'(1)) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                    case (op_r)
                        OP_MULT:  {hi_next, lo_next} = sprod;
                        OP_MULTU: {hi_next, lo_next} = uprod;
                        OP_DIV:   if (b_r != '0) {hi_next, lo_next} = {r_s, q_s};
                        OP_DIVU:  if (b_r != '0) {hi_next, lo_next} = {r_u, q_u};
`ifdef MDU_MADD_EN
                        3'd6:     {hi_next, lo_next} = {hi_r, lo_r} + sprod;
                        3'd7:     {hi_next, lo_next} = {hi_r, lo_r} - sprod;
`endif
                        default: ;
                    endcase
                end else begin
                    cnt_next = cnt - CW'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            op_r  <= '0;
            a_r   <= '0;
            b_r   <= '0;
            hi_r  <= '0;
            lo_r  <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            op_r  <= op_next;
            a_r   <= a_next;
            b_r   <= b_next;
            hi_r  <= hi_next;
            lo_r  <= lo_next;
        end
    end

endmodule

// File: tb/tb_mult_div.sv
module tb_mult_div;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = '0;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic        busy;
    logic [31:0] HI, LO;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    mult_div #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .A(A), .B(B), .busy(busy), .HI(HI), .LO(LO)
    );

    always #5 clk = ~clk;

    // Reference: result and busy length straight from the instruction definitions.
    function automatic void model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                  output int n, output logic [31:0] h, output logic [31:0] l);
        longint          sa = longint'($signed(a));
        longint          sb = longint'($signed(b));
        longint unsigned ua = {32'd0, a};
        longint unsigned ub = {32'd0, b};
        logic [63:0]     p;
        h = m_hi; l = m_lo; n = 0;
        case (o)
            3'd0: begin n = MC; p = sa * sb; {h, l} = p; end
            3'd1: begin n = MC; p = ua * ub; {h, l} = p; end
            3'd2: begin n = DC; if (b != 0) begin l = 32'(sa / sb); h = 32'(sa % sb); end end
            3'd3: begin n = DC; if (b != 0) begin l = 32'(ua / ub); h = 32'(ua % ub); end end
            3'd4: h = a;
            3'd5: l = a;
`ifdef MDU_MADD_EN
            3'd6: begin n = MC; p = sa * sb; {h, l} = {m_hi, m_lo} + p; end
            3'd7: begin n = MC; p = sa * sb; {h, l} = {m_hi, m_lo} - p; end
`endif
            default: ;
        endcase
    endfunction

    // Issue one op; optionally fire an extra start (op intf_op) on busy cycle intf.
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input int intf, input logic [2:0] intf_op, input string name);
        int          exp_n, n;
        logic [31:0] eh, el, oh, ol;
        bit          held;
        model(o, a, b, exp_n, eh, el);
        oh = m_hi; ol = m_lo;
        start = 1'b1; op = o; A = a; B = b;
        @(posedge clk); #1;
        start = 1'b0; op = 3'($urandom); A = $urandom; B = $urandom;
        n = 0; held = 1'b1;
        while (busy && n < 40) begin
            n++;
            if (HI !== oh || LO !== ol) held = 1'b0;
            if (n == intf) begin
                start = 1'b1; op = intf_op; A = $urandom; B = $urandom;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        n_cmp++;
        if (n !== exp_n) begin n_bad++; $display("FAIL %s busy_cycles got %0d want %0d", name, n, exp_n); end
        n_cmp++;
        if (held !== 1'b1) begin n_bad++; $display("FAIL %s hold_during_busy got changed want held", name); end
        n_cmp++;
        if (HI !== eh) begin n_bad++; $display("FAIL %s HI got %h want %h", name, HI, eh); end
        n_cmp++;
        if (LO !== el) begin n_bad++; $display("FAIL %s LO got %h want %h", name, LO, el); end
        m_hi = eh; m_lo = el;
    endtask

    task automatic test_reset();
        #1;
        n_cmp++;
        if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
            n_bad++; $display("FAIL powerup got busy=%b HI=%h LO=%h want 0/0/0", busy, HI, LO);
        end
        repeat (3) @(posedge clk);
        #1; reset = 1'b0;
        n_cmp++;
        if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
            n_bad++; $display("FAIL reset got busy=%b HI=%h LO=%h want 0/0/0", busy, HI, LO);
        end
        m_hi = '0; m_lo = '0;
    endtask

    task automatic test_mult();
        run_op(3'd0, 32'hFFFFFFFE, 32'd3, 0, 3'd0, "mult_dir");
        n_cmp++;
        if ({HI, LO} !== 64'hFFFFFFFF_FFFFFFFA) begin n_bad++; $display("FAIL mult_const got %h%h want FFFFFFFFFFFFFFFA", HI, LO); end
        run_op(3'd1, 32'hFFFFFFFE, 32'd3, 0, 3'd0, "multu_dir");
        n_cmp++;
        if ({HI, LO} !== 64'h00000002_FFFFFFFA) begin n_bad++; $display("FAIL multu_const got %h%h want 00000002FFFFFFFA", HI, LO); end
        for (int i = 0; i < 12; i++) run_op(3'($urandom_range(1)), $urandom, $urandom, 0, 3'd0, "mult_rnd");
    endtask

    task automatic test_div();
        run_op(3'd2, 32'hFFFFFFF9, 32'd2, 0, 3'd0, "div_dir");
        n_cmp++;
        if ({HI, LO} !== 64'hFFFFFFFF_FFFFFFFD) begin n_bad++; $display("FAIL div_const got %h%h want FFFFFFFFFFFFFFFD", HI, LO); end
        run_op(3'd3, 32'd7, 32'd0, 0, 3'd0, "divu_zero");
        run_op(3'd2, 32'h12345678, 32'd0, 0, 3'd0, "div_zero");
        run_op(3'd2, 32'h80000000, 32'hFFFFFFFF, 0, 3'd0, "div_ovf");
        n_cmp++;
        if ({HI, LO} !== 64'h00000000_80000000) begin n_bad++; $display("FAIL div_ovf_const got %h%h want 0000000080000000", HI, LO); end
        for (int i = 0; i < 10; i++) begin
            logic [31:0] b;
            b = (i % 3 == 0) ? 32'($signed(8'($urandom))) : $urandom;
            run_op(3'($urandom_range(3, 2)), $urandom, b, 0, 3'd0, "div_rnd");
        end
    endtask

    task automatic test_mt();
        run_op(3'd4, 32'h00001234, $urandom, 0, 3'd0, "mthi");
        n_cmp++;
        if (HI !== 32'h00001234) begin n_bad++; $display("FAIL mthi_const got %h want 00001234", HI); end
        run_op(3'd5, 32'hCAFEF00D, $urandom, 0, 3'd0, "mtlo");
    endtask

    task automatic test_busy_ignore();
        run_op(3'd2, 32'd1000, 32'd7, 2, 3'd0, "div_ign_mult");
        n_cmp++;
        if ({HI, LO} !== {32'd6, 32'd142}) begin n_bad++; $display("FAIL div_ign_const got %h%h want %h%h", HI, LO, 32'd6, 32'd142); end
        run_op(3'd0, $urandom, $urandom, 3, 3'd4, "mult_ign_mthi");
        run_op(3'd3, $urandom, $urandom, 9, 3'd5, "divu_ign_mtlo");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 6; i++) run_op(3'($urandom_range(3)), $urandom, $urandom | 32'd1, 0, 3'd0, "b2b");
    endtask

    task automatic test_reset_abort();
        int k;
        start = 1'b1; op = 3'd2; A = 32'hFFFFFFF9; B = 32'd2;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        n_cmp++;
        if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
            n_bad++; $display("FAIL rst_abort got busy=%b HI=%h LO=%h want 0/0/0", busy, HI, LO);
        end
        k = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) k++;
        end
        n_cmp++;
        if (k !== 0) begin n_bad++; $display("FAIL rst_no_late_write got %0d bad cycles want 0", k); end
        m_hi = '0; m_lo = '0;
    endtask

    task automatic test_madd();
        run_op(3'd4, 32'd0, 32'd0, 0, 3'd0, "madd_pre_hi");
        run_op(3'd5, 32'hFFFFFFFF, 32'd0, 0, 3'd0, "madd_pre_lo");
        run_op(3'd6, 32'd1, 32'd1, 0, 3'd0, "madd_dir");
        for (int i = 0; i < 8; i++) run_op(3'($urandom_range(7, 6)), $urandom, $urandom, 0, 3'd0, "madd_rnd");
    endtask

    task automatic test_random();
        for (int i = 0; i < 30; i++) run_op(3'($urandom), $urandom, (i % 5 == 0) ? 32'd0 : $urandom, 0, 3'd0, "mix_rnd");
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_mt();
        test_busy_ignore();
        test_back_to_back();
        test_reset_abort();
        test_madd();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
